// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads to instruction memory,
// and buffers {pc, instr} in a small FIFO handed to decode over valid/ready.
module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = 3;

    logic [31:0]      pc_reg;
    logic [31:0]      inflight_pc_reg;
    logic [31:0]      imem_addr_reg;
    logic             imem_rd_en_reg;
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [PTR_W-1:0] head_next, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [31:0] fifo_pc    [DEPTH];
    logic [31:0] fifo_instr [DEPTH];

    logic push, pop, issue;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // The outstanding read always lands the cycle after it issued; a redirect drops it.
    assign push = imem_rd_en_reg && !redirect_en;
    assign pop  = (count_reg != '0) && instr_ready && !redirect_en;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) begin
            tail_next = ptr_inc(tail_reg);
        end
        if (pop) begin
            head_next = ptr_inc(head_reg);
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Credit: buffered words after this edge plus the new request must fit the FIFO.
    assign issue = fetch_en && !redirect_en && (int'(count_next) < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            imem_addr_reg   <= '0;
            imem_rd_en_reg  <= 1'b0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else if (redirect_en) begin
            pc_reg         <= {redirect_pc[31:2], 2'b00};
            imem_rd_en_reg <= 1'b0;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
            imem_rd_en_reg <= issue;
            if (issue) begin
                imem_addr_reg   <= {2'b00, pc_reg[31:2]};
                inflight_pc_reg <= pc_reg;
                pc_reg          <= pc_reg + 32'd4;
            end
        end
    end

    // Storage carries no reset; entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_pc[tail_reg]    <= inflight_pc_reg;
            fifo_instr[tail_reg] <= imem_instr;
        end
    end

    assign imem_addr   = imem_addr_reg;
    assign imem_rd_en  = imem_rd_en_reg;
    assign instr_valid = (count_reg != '0);
    assign instr_out   = instr_valid ? fifo_instr[head_reg] : '0;
    assign pc_out      = instr_valid ? fifo_pc[head_reg]    : '0;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: expected {pc, instr} streams are queued when a
// fetch segment starts and popped on every decode handshake.
module tb_imem_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_instr = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   delivered = 0;

    always #5 clk = ~clk;

    imem_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_instr  (imem_instr),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd4) begin
            return 32'hA0 + a;
        end
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory with one-cycle latency: samples the request on the negedge after launch.
    always @(negedge clk) begin
        if (imem_rd_en) begin
            imem_instr <= mem_word(imem_addr);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic seed(input logic [31:0] start_pc, input int n);
        logic [31:0] p;
        exp_t e;
        exp_q.delete();
        p = start_pc;
        for (int i = 0; i < n; i++) begin
            e.pc    = p;
            e.instr = mem_word({2'b00, p[31:2]});
            exp_q.push_back(e);
            p = p + 32'd4;
        end
    endtask

    // One clock: capture the handshake seen before the edge, then score it after the edge.
    task automatic step();
        logic        hs;
        logic        credit_ok;
        logic [31:0] p, w;
        exp_t        e;
        hs = instr_valid && instr_ready && !redirect_en;
        p  = pc_out;
        w  = instr_out;
        if (imem_rd_en && !redirect_en) begin
            credit_ok = (int'(dut.count_reg) < DEPTH);
            check_val("push_not_full", 32'(credit_ok), 32'd1);
        end
        @(posedge clk);
        #1;
        if (hs) begin
            delivered++;
            $display("deliver pc=%08h instr=%08h", p, w);
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("pc_out", p, e.pc);
                check_val("instr_out", w, e.instr);
            end
        end
    endtask

    initial begin
        logic [31:0] hold_instr, hold_pc;
        int          d0;

        rst         = 1'b1;
        fetch_en    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check_val("rst_addr", imem_addr, 32'd0);
        check_val("rst_pc_out", pc_out, 32'd0);
        check_val("rst_instr_out", instr_out, 32'd0);

        // Startup stream: addresses 0..3, first valid after the second edge.
        rst         = 1'b0;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        seed(32'h0, 200);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("startup_addr", imem_addr, 32'(k));
            check_val("startup_valid", 32'(instr_valid), (k >= 1) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("throughput_valid", 32'(instr_valid), 32'd1);
        end

        // Back-pressure: head holds, issue stops once the FIFO is full.
        instr_ready = 1'b0;
        hold_instr  = instr_out;
        hold_pc     = pc_out;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("hold_instr", instr_out, hold_instr);
            check_val("hold_pc", pc_out, hold_pc);
        end
        check_val("stall_rd_en", 32'(imem_rd_en), 32'd0);
        check_val("stall_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // Redirect with a full FIFO and a concurrent (ignored) pop.
        instr_ready = 1'b0;
        step();
        step();
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0103;
        instr_ready = 1'b1;
        step();
        redirect_en = 1'b0;
        seed(32'h0000_0100, 100);
        check_val("redir_valid0", 32'(instr_valid), 32'd0);
        step();
        check_val("redir_valid1", 32'(instr_valid), 32'd0);
        step();
        check_val("redir_valid2", 32'(instr_valid), 32'd1);
        check_val("redir_first_pc", pc_out, 32'h0000_0100);
        for (int k = 0; k < 6; k++) step();

        // Asynchronous reset mid-cycle while a read is outstanding.
        @(negedge clk);
        #1;
        check_val("pre_rst_rd_en", 32'(imem_rd_en), 32'd1);
        rst = 1'b1;
        #1;
        check_val("arst_valid", 32'(instr_valid), 32'd0);
        check_val("arst_rd_en", 32'(imem_rd_en), 32'd0);
        check_val("arst_addr", imem_addr, 32'd0);
        check_val("arst_pc_out", pc_out, 32'd0);
        check_val("arst_instr_out", instr_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seed(32'h0, 200);
        step();
        step();
        check_val("arst_first_pc", pc_out, 32'h0);
        check_val("arst_first_instr", instr_out, 32'hA0);
        for (int k = 0; k < 4; k++) step();

        // fetch_en toggling: deliveries remain consecutive.
        for (int k = 0; k < 20; k++) begin
            fetch_en = k[0];
            step();
        end
        fetch_en = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // PC wrap at the top of the address space.
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_en = 1'b0;
        seed(32'hFFFF_FFFC, 50);
        d0 = delivered;
        for (int k = 0; k < 6; k++) step();
        check_val("wrap_count", 32'(delivered - d0), 32'd4);

        // Drain with fetch disabled.
        fetch_en = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check_val("drain_valid", 32'(instr_valid), 32'd0);
        check_val("drain_rd_en", 32'(imem_rd_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
